mem_bus_arbiter: RTL and testbench

- Shares the single memory interface port (ROM/RAM/IO address decoder) between the instruction-fetch requester and the load/store requester.
- Arbitrates the two requesters and latches the winner's command.
- Drives exactly one memory access per transaction.
- Waits the fixed memory read latency, then returns data to the winner with a one-cycle acknowledge.
- Sits between the core's fetch/LSU stages and the memory interface.

---
 rtl/mem_bus_arbiter_pkg.sv | 20 ++
 rtl/mem_bus_arbiter_arb_pick.sv | 33 +++
 rtl/mem_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: the FSM state encoding and the
// grant identifiers that the winner-select logic and the top agree on.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_FETCH = 2'd1,
        GNT_DATA  = 2'd2
    } grant_t;

    localparam int CNT_W = 3;

endpackage

// File: rtl/mem_bus_arbiter_arb_pick.sv
// Combinational winner select between fetch and load/store requesters.
// MEM_ARB_RR_EN: round-robin on contention; otherwise data beats fetch.
module mem_bus_arbiter_arb_pick
    import mem_bus_arbiter_pkg::*;
(
    input  logic   i_if_req,
    input  logic   i_d_req,
    input  grant_t i_last_grant,
    output grant_t o_pick
);

`ifndef MEM_ARB_RR_EN
    logic w_unused_last_grant;
    assign w_unused_last_grant = ^i_last_grant;
`endif

    always_comb begin
        o_pick = GNT_NONE;
        if (i_if_req && i_d_req) begin
`ifdef MEM_ARB_RR_EN
            // Whoever did not win last time goes first.
            o_pick = (i_last_grant == GNT_DATA) ? GNT_FETCH : GNT_DATA;
`else
            o_pick = GNT_DATA;
`endif
        end else if (i_d_req) begin
            o_pick = GNT_DATA;
        end else if (i_if_req) begin
            o_pick = GNT_FETCH;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between fetch and load/store: latch winner, one access,
// wait MEM_LAT for reads, ack for one cycle. Build option: MEM_ARB_RR_EN.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_ack,
    output logic [XLEN-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wd,
    output logic            d_ack,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wd,
    input  logic [XLEN-1:0] mem_rd,
    output logic            busy
);

    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT);

    state_t             r_state;
    state_t             w_state_nxt;
    grant_t             r_grant;
    grant_t             r_last_grant;
    grant_t             w_pick;
    logic               r_we;
    logic [XLEN-1:0]    r_addr;
    logic [XLEN-1:0]    r_wd;
    logic [XLEN-1:0]    r_if_rdata;
    logic [XLEN-1:0]    r_d_rdata;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_load_cmd;
    logic               w_capture;

    mem_bus_arbiter_arb_pick u_arb_pick (
        .i_if_req     (if_req),
        .i_d_req      (d_req),
        .i_last_grant (r_last_grant),
        .o_pick       (w_pick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load_cmd  = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick != GNT_NONE) begin
                    w_load_cmd  = 1'b1;
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: w_state_nxt = r_we ? ST_RESP : ST_WAIT;
            ST_WAIT: begin
                // Last wait cycle: mem_rd is now MEM_LAT cycles past the address.
                if (r_cnt == CNT_W'(1)) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy     = (r_state != ST_IDLE);
    assign mem_we   = (r_state == ST_ADDR) && r_we;
    assign mem_addr = r_addr;
    assign mem_wd   = r_wd;
    assign if_ack   = (r_state == ST_RESP) && (r_grant == GNT_FETCH);
    assign d_ack    = (r_state == ST_RESP) && (r_grant == GNT_DATA);
    assign if_rdata = r_if_rdata;
    assign d_rdata  = r_d_rdata;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_grant      <= GNT_NONE;
            r_last_grant <= GNT_FETCH;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wd         <= '0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
            r_cnt        <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_cmd) begin
                r_grant <= w_pick;
                if (w_pick == GNT_DATA) begin
                    r_addr <= d_addr;
                    r_wd   <= d_wd;
                    r_we   <= d_we;
                end else begin
                    r_addr <= if_addr;
                    r_wd   <= '0;
                    r_we   <= 1'b0;
                end
            end
            if (r_state == ST_ADDR) begin
                r_cnt <= LAT_INIT;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_capture) begin
                if (r_grant == GNT_FETCH) begin
                    r_if_rdata <= mem_rd;
                end else begin
                    r_d_rdata  <= mem_rd;
                end
            end
            if (r_state == ST_RESP) begin
                r_last_grant <= r_grant;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) driven by
// directed and randomized transactions against a transaction-level model.
module tb_mem_bus_arbiter;

    localparam int XLEN = 32;
    localparam int GF   = 1;
    localparam int GD   = 2;

    logic                 clk = 1'b0;
    logic [1:0]           rstn;
    logic [1:0]           if_req, if_ack, d_req, d_we, d_ack, mem_we, busy;
    logic [1:0][XLEN-1:0] if_addr, if_rdata, d_addr, d_wd, d_rdata;
    logic [1:0][XLEN-1:0] mem_addr, mem_wd, mem_rd;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state per instance: last winner and held read data per port.
    int          mlg   [2];
    logic [31:0] mrd_f [2];
    logic [31:0] mrd_d [2];

    always #5 clk = ~clk;

    mem_bus_arbiter #(.MEM_LAT(1), .XLEN(XLEN)) u_dut1 (
        .clk(clk), .rstn(rstn[0]),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ack(if_ack[0]), .if_rdata(if_rdata[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wd(d_wd[0]),
        .d_ack(d_ack[0]), .d_rdata(d_rdata[0]),
        .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wd(mem_wd[0]), .mem_rd(mem_rd[0]),
        .busy(busy[0])
    );

    mem_bus_arbiter #(.MEM_LAT(3), .XLEN(XLEN)) u_dut3 (
        .clk(clk), .rstn(rstn[1]),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ack(if_ack[1]), .if_rdata(if_rdata[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wd(d_wd[1]),
        .d_ack(d_ack[1]), .d_rdata(d_rdata[1]),
        .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wd(mem_wd[1]), .mem_rd(mem_rd[1]),
        .busy(busy[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int k, input bit pf, input bit pd);
        if (pf && pd) begin
`ifdef MEM_ARB_RR_EN
            return (mlg[k] == GD) ? GF : GD;
`else
            return GD;
`endif
        end
        return pd ? GD : GF;
    endfunction

    // One scenario: requests raised in cycle 0, each requester drops req once acked.
    task automatic scenario(input int k, input string tag, input bit fon, input bit don,
                            input bit dwe, input logic [31:0] fa, input logic [31:0] da,
                            input logic [31:0] dwd, input bit one_shot, input int rst_at,
                            input bit rd_fixed, input logic [31:0] rd_val);
        logic [31:0] rdh [0:63];
        logic [31:0] ea, ew;
        bit act, pf, pd, st, drop, done, after_rst;
        int ts, ta, win, lat, c;
        lat = (k == 0) ? 1 : 3;
        act = 0; done = 0; after_rst = 0; st = 0; drop = 0;
        ts = 0; ta = 0; win = 0; c = 0; ea = '0; ew = '0;
        if_req[k] = fon; if_addr[k] = fa;
        d_req[k]  = don; d_we[k] = dwe; d_addr[k] = da; d_wd[k] = dwd;
        while (!done && c < 60) begin
            rdh[c]    = rd_fixed ? rd_val : $urandom;
            mem_rd[k] = rdh[c];
            if (c == rst_at) rstn[k] = 1'b0;
            pf = if_req[k];
            pd = d_req[k];
            if (act && c > ta) act = 0;
            if (!act && (pf || pd)) begin
                act  = 1;
                ts   = c;
                win  = pick(k, pf, pd);
                st   = (win == GD) && d_we[k];
                ta   = c + (st ? 2 : 2 + lat);
                ea   = (win == GD) ? d_addr[k] : if_addr[k];
                ew   = (win == GD) ? d_wd[k] : 32'h0;
                drop = 1'($urandom_range(0, 1));
            end
            if (act && c == ta) begin
                if (!st) begin
                    if (win == GD) mrd_d[k] = rdh[ts + 1 + lat];
                    else           mrd_f[k] = rdh[ts + 1 + lat];
                end
                mlg[k] = win;
            end
            if (!act && !pf && !pd) done = 1;
            #1;
            chk($sformatf("%s.k%0d.ctl@%0d", tag, k, c),
                {28'h0, busy[k], if_ack[k], d_ack[k], mem_we[k]},
                {28'h0, act && c > ts, act && c == ta && win == GF,
                 act && c == ta && win == GD, act && st && c == ts + 1});
            if (act && c > ts) begin
                chk($sformatf("%s.k%0d.addr@%0d", tag, k, c), mem_addr[k], ea);
                chk($sformatf("%s.k%0d.wd@%0d", tag, k, c), mem_wd[k], ew);
            end
            if (after_rst) begin
                chk($sformatf("%s.k%0d.rst_addr", tag, k), mem_addr[k], 32'h0);
                chk($sformatf("%s.k%0d.rst_wd", tag, k), mem_wd[k], 32'h0);
            end
            chk($sformatf("%s.k%0d.if_rdata@%0d", tag, k, c), if_rdata[k], mrd_f[k]);
            chk($sformatf("%s.k%0d.d_rdata@%0d", tag, k, c), d_rdata[k], mrd_d[k]);
            if (!done) begin
                @(negedge clk);
                rstn[k] = 1'b1;
                if (c == rst_at) begin
                    act = 0; after_rst = 1;
                    mrd_f[k] = '0; mrd_d[k] = '0; mlg[k] = GF;
                    if_req[k] = 1'b0; d_req[k] = 1'b0;
                end else if (act && c == ta) begin
                    if (win == GF) if_req[k] = 1'b0;
                    else           d_req[k]  = 1'b0;
                    if (one_shot) begin
                        if_req[k] = 1'b0; d_req[k] = 1'b0;
                    end
                end else if (act && c >= ts) begin
                    // Owner's command lines wander; the latched copy must not.
                    if (c == ts && drop) begin
                        if (win == GF) if_req[k] = 1'b0;
                        else           d_req[k]  = 1'b0;
                    end
                    if (win == GF) begin
                        if_addr[k] = $urandom;
                    end else begin
                        d_addr[k] = $urandom; d_wd[k] = $urandom;
                        d_we[k]   = 1'($urandom_range(0, 1));
                    end
                end
                c++;
            end
        end
        n_assert++;
        assert (done) else begin
            n_fail++;
            $error("FAIL %s.k%0d.timeout: observed cycles %0d required idle within 60", tag, k, c);
        end
        if_req[k] = 1'b0; d_req[k] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rstn = '0; if_req = '0; d_req = '0; d_we = '0;
        if_addr = '0; d_addr = '0; d_wd = '0; mem_rd = '0;
        for (int k = 0; k < 2; k++) begin
            mlg[k] = GF; mrd_f[k] = '0; mrd_d[k] = '0;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset.k%0d.ctl", k), {28'h0, busy[k], if_ack[k], d_ack[k], mem_we[k]}, 32'h0);
            chk($sformatf("reset.k%0d.addr", k), mem_addr[k], 32'h0);
            chk($sformatf("reset.k%0d.wd", k), mem_wd[k], 32'h0);
            chk($sformatf("reset.k%0d.rdata", k), if_rdata[k] | d_rdata[k], 32'h0);
        end
        @(negedge clk);
        rstn = '1;
        for (int k = 0; k < 2; k++) begin
            scenario(k, "fetch", 1, 0, 0, 32'h0001_0004, 32'h0, 32'h0, 0, -1, 1, 32'hDEAD_BEEF);
            scenario(k, "store", 0, 1, 1, 32'h0, 32'h0010_0008, 32'h1234_5678, 0, -1, 0, 32'h0);
            scenario(k, "load", 0, 1, 0, 32'h0, 32'h0010_0010, 32'h0, 0, -1, 0, 32'h0);
            scenario(k, "both", 1, 1, 0, 32'h0001_0000, 32'h0010_0000, 32'h5A5A_5A5A, 0, -1, 0, 32'h0);
            for (int r = 0; r < 4; r++)
                scenario(k, $sformatf("contend%0d", r), 1, 1, 0, 32'h0002_0000 + 32'(r),
                         32'h0010_0000, 32'h0, 1, -1, 0, 32'h0);
            scenario(k, "rst_wait", 0, 1, 0, 32'h0, 32'h0030_0000, 32'h0, 0, 2, 0, 32'h0);
            scenario(k, "post_rst", 1, 0, 0, 32'h0004_0000, 32'h0, 32'h0, 0, -1, 0, 32'h0);
            for (int r = 0; r < 8; r++) begin
                bit fon, don;
                fon = 1'($urandom_range(0, 1));
                don = 1'($urandom_range(0, 1));
                if (!fon && !don) fon = 1;
                scenario(k, $sformatf("rand%0d", r), fon, don, 1'($urandom_range(0, 1)),
                         $urandom, $urandom, $urandom, 0, -1, 0, 32'h0);
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
